vfpu_result_writer: RTL
=======================

Name: vfpu_result_writer

Overview:
- Consumer end of the VFPU result HWPE-stream: sinks the `result_stream_source` produced by the VFPU streamer.
- Buffers results in a small FIFO and writes them to TCDM through a single request/grant master port.
- A strided address generator places the results, and a length counter terminates the job.
- Sits between the VFPU streamer and the TCDM interconnect; the HWPE controller drives it with start/base/stride/length.

Parameters:
- DATA_WIDTH, 32, stream and TCDM data width (FP_WIDTH results).
- ADDR_WIDTH, 32, TCDM byte address width.
- LEN_WIDTH, 16, width of the element count.
- FIFO_DEPTH, 4, result buffer entries; power of two, minimum 2.

Ports:
- clk_i  in  1  clock; all logic rising-edge.
- rst_i  in  1  synchronous reset, active-high.
- clear_i  in  1  synchronous soft clear, same effect as rst_i.
- start_i  in  1  one-cycle job start pulse; sampled only in IDLE.
- base_addr_i  in  ADDR_WIDTH  first write byte address; latched on start.
- stride_i  in  ADDR_WIDTH  byte increment between results; latched on start; two's complement.
- len_i  in  LEN_WIDTH  number of results to write; latched on start.
- result_stream_sink  hwpe_stream_intf_stream.sink  DATA_WIDTH  result stream (valid/ready/data/strb).
- tcdm_req_o  out  1  write request.
- tcdm_gnt_i  in  1  grant; a transfer completes on req&gnt.
- tcdm_add_o  out  ADDR_WIDTH  write address.
- tcdm_wen_o  out  1  constant 0 (write).
- tcdm_be_o  out  DATA_WIDTH/8  byte enables = stored strb.
- tcdm_data_o  out  DATA_WIDTH  write data.
- busy_o  out  1  high in RUN and DRAIN.
- done_o  out  1  one-cycle pulse at job end.
- count_o  out  LEN_WIDTH  number of results granted so far in the current job.

Behaviour:
- Reset/clear values:
  - FSM = IDLE; FIFO emptied.
  - tcdm_req_o=0, tcdm_add_o=0, tcdm_be_o=0, tcdm_data_o=0.
  - busy_o=0, done_o=0, count_o=0, sink ready=0.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE --start_i & len_i!=0--> RUN. Latches base/stride/len; clears the accepted counter, the granted counter and count_o.
  - IDLE --start_i & len_i==0--> DONE. No stream beats, no requests.
  - RUN --last beat accepted (accepted == len-1 and handshake)--> DRAIN.
  - DRAIN --last grant (granted == len-1 and req&gnt)--> DONE.
  - DONE --> IDLE unconditionally. done_o=1 only in DONE, for one cycle.
  - start_i outside IDLE is ignored.
- Sink handshake:
  - ready = (state==RUN) & FIFO not full. It is not a function of valid.
  - A beat is pushed on valid&ready, storing {strb, data}.
  - Ready is 0 in IDLE, DRAIN and DONE, so beats beyond len are never consumed.
- FIFO:
  - FIFO_DEPTH entries, registered, no bypass.
  - A beat accepted in cycle N can drive tcdm_req_o at the earliest in cycle N+1.
  - Simultaneous push and pop is allowed and leaves occupancy unchanged.
  - With ready based on not-full, a full FIFO never receives a push.
- TCDM master:
  - tcdm_req_o = FIFO not empty, in RUN or DRAIN.
  - add/data/be are driven from the FIFO head and current address. They must remain stable while req=1 and gnt=0.
  - On req&gnt: pop FIFO, address += stride (modulo 2^ADDR_WIDTH wrap, no saturation), count_o += 1.
  - First request address = base_addr_i.
- Arithmetic:
  - Address for element k = base + k*stride, computed by accumulation, not multiplication.
  - Counters are LEN_WIDTH wide. len max = 2^LEN_WIDTH-1; no counter wrap within a job.
- Reset/clear mid-job:
  - Abandons the job in the next cycle: FSM to IDLE, FIFO flushed, req drops, no done pulse.
  - Any outstanding ungranted request is dropped; the issuer guarantees that is acceptable.
- Stream strb is forwarded verbatim; a partial strb yields a partial write, never an error.

Test Plan:
- Basic: base=0x1000, stride=4, len=3, beats 0x3F800000, 0x40000000, 0x40400000, gnt tied 1.
  - Writes go to 0x1000/0x1004/0x1008 with be=0xF.
  - count_o steps 1, 2, 3; done_o pulses once, 2 cycles after the last grant-cycle push path; busy_o low after.
- Backpressure: gnt=0 for 10 cycles, 8 beats offered.
  - Exactly FIFO_DEPTH=4 accepted, then ready=0.
  - req/add/data held stable throughout; on gnt=1 all 8 are written in order.
- Zero length: start with len=0.
  - done_o pulses on the cycle after start; no req; sink ready stays 0.
- Negative stride/wrap: base=0x00000004, stride=0xFFFFFFFC, len=3.
  - Addresses are 0x4, 0x0, 0xFFFFFFFC.
- Over-supply and ignored start: len=2 while upstream holds valid with 5 beats.
  - Only 2 consumed; a start_i pulse during RUN does not re-latch parameters.
- Clear mid-job: len=6; assert clear_i after 3 grants while req is pending.
  - Next cycle: req=0, busy_o=0, count_o=0, no done_o.
  - A new start then runs correctly from its new base.

Source files
------------

// File: rtl/vfpu_result_writer.sv
// vfpu_result_writer: sinks the VFPU result stream, buffers beats in a small
// FIFO and writes them to TCDM at base + k*stride through a req/gnt master.
module vfpu_result_writer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  // Job control
  input  logic                    start_i,
  input  logic [ADDR_WIDTH-1:0]   base_addr_i,
  input  logic [ADDR_WIDTH-1:0]   stride_i,
  input  logic [LEN_WIDTH-1:0]    len_i,
  // Result stream sink
  input  logic                    result_valid_i,
  output logic                    result_ready_o,
  input  logic [DATA_WIDTH-1:0]   result_data_i,
  input  logic [DATA_WIDTH/8-1:0] result_strb_i,
  // TCDM write master
  output logic                    tcdm_req_o,
  input  logic                    tcdm_gnt_i,
  output logic [ADDR_WIDTH-1:0]   tcdm_add_o,
  output logic                    tcdm_wen_o,
  output logic [DATA_WIDTH/8-1:0] tcdm_be_o,
  output logic [DATA_WIDTH-1:0]   tcdm_data_o,
  // Status
  output logic                    busy_o,
  output logic                    done_o,
  output logic [LEN_WIDTH-1:0]    count_o
);

  localparam int unsigned BeWidth    = DATA_WIDTH / 8;
  localparam int unsigned EntryWidth = BeWidth + DATA_WIDTH;
  localparam int unsigned PtrWidth   = $clog2(FIFO_DEPTH);
  // Pointers carry one extra wrap bit to tell full from empty.
  localparam int unsigned PtrFull    = PtrWidth + 1;

  localparam logic [PtrFull-1:0]   PtrOne = PtrFull'(1);
  localparam logic [LEN_WIDTH-1:0] LenOne = LEN_WIDTH'(1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  state_e                 state_q;
  logic                   busy_q;
  logic                   done_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [ADDR_WIDTH-1:0]  stride_q;
  logic [LEN_WIDTH-1:0]   len_q;
  logic [LEN_WIDTH-1:0]   accepted_q;
  logic [LEN_WIDTH-1:0]   granted_q;

  logic [EntryWidth-1:0]  fifo_mem_q [FIFO_DEPTH];
  logic [PtrFull-1:0]     wr_ptr_q;
  logic [PtrFull-1:0]     rd_ptr_q;

  logic                   flush;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic                   run_or_drain;
  logic                   push;
  logic                   pop;
  logic                   last_accept;
  logic                   last_grant;
  logic [EntryWidth-1:0]  head;
  logic [PtrWidth-1:0]    wr_idx;
  logic [PtrWidth-1:0]    rd_idx;

  // Soft clear behaves exactly like reset.
  assign flush = rst_i | clear_i;

  assign wr_idx     = wr_ptr_q[PtrWidth-1:0];
  assign rd_idx     = rd_ptr_q[PtrWidth-1:0];
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PtrWidth] != rd_ptr_q[PtrWidth]) && (wr_idx == rd_idx);
  assign head       = fifo_mem_q[rd_idx];

  assign run_or_drain = (state_q == StRun) || (state_q == StDrain);

  // Ready depends only on state and occupancy, never on valid.
  assign result_ready_o = (state_q == StRun) && !fifo_full;
  assign push           = result_valid_i && result_ready_o;

  assign tcdm_req_o = run_or_drain && !fifo_empty;
  assign pop        = tcdm_req_o && tcdm_gnt_i;

  assign last_accept = push && (accepted_q == len_q - LenOne);
  assign last_grant  = pop && (granted_q == len_q - LenOne);

  // Bus fields come straight from the FIFO head and the address accumulator,
  // so they hold still while a request waits for its grant. Zero when idle.
  assign tcdm_add_o  = tcdm_req_o ? addr_q : '0;
  assign tcdm_data_o = tcdm_req_o ? head[DATA_WIDTH-1:0] : '0;
  assign tcdm_be_o   = tcdm_req_o ? head[EntryWidth-1:DATA_WIDTH] : '0;
  assign tcdm_wen_o  = 1'b0;

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign count_o = granted_q;

  // FIFO storage: written on every accepted beat, no reset needed.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem_q[wr_idx] <= {result_strb_i, result_data_i};
    end
  end

  // FIFO pointers: push and pop may coincide, leaving occupancy unchanged.
  always_ff @(posedge clk_i) begin
    if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrOne;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrOne;
      end
    end
  end

  // Job FSM with address accumulator, beat/grant counters and status flags.
  always_ff @(posedge clk_i) begin
    if (flush) begin
      state_q    <= StIdle;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      addr_q     <= '0;
      stride_q   <= '0;
      len_q      <= '0;
      accepted_q <= '0;
      granted_q  <= '0;
    end else begin
      if (push) begin
        accepted_q <= accepted_q + LenOne;
      end
      // Address advances by accumulation; wraps modulo 2^ADDR_WIDTH.
      if (pop) begin
        addr_q    <= addr_q + stride_q;
        granted_q <= granted_q + LenOne;
      end
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            addr_q     <= base_addr_i;
            stride_q   <= stride_i;
            len_q      <= len_i;
            accepted_q <= '0;
            granted_q  <= '0;
            if (len_i != '0) begin
              state_q <= StRun;
              busy_q  <= 1'b1;
            end else begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end
        end
        StRun: begin
          if (last_accept) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (last_grant) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
